rr_mux_reg: RTL

- Parametrised N-channel, WIDTH-bit registered multiplexer; successor to the plain 2:1 select mux.
- Selects one input channel per cycle, by explicit select or by round-robin arbitration.
- Drives a single output register with valid/ready handshake.
- Feeds operand/partial-product paths of the sequential multiplier datapath.

---
 rtl/rr_mux_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - N-channel registered mux with fixed-select or round-robin grant and valid/ready output.
// Optional transfer counter port xfer_cnt enabled by defining RR_MUX_REG_CNT_EN.
module rr_mux_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef RR_MUX_REG_CNT_EN
  ,
  output logic [15:0]               xfer_cnt
`endif
);

  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic [WIDTH-1:0] gnt_data;
  logic [SEL_W-1:0] rr_ptr;

  assign load = !out_valid || out_ready;

  // Round-robin search starts one past the last winner so every valid channel is served in turn.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (!mode) begin
      if (int'(sel) < CHANNELS) begin
        gnt     = sel;
        gnt_vld = in_valid[sel];
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        if (!gnt_vld && in_valid[(int'(rr_ptr) + k) % CHANNELS]) begin
          gnt     = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = load && gnt_vld && (gnt == SEL_W'(i));
    end
  end

  // gnt_vld already implies in_valid of the granted channel.
  assign xfer = load && gnt_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
    end else begin
      if (xfer) begin
        out_data  <= gnt_data;
        out_chan  <= gnt;
        out_valid <= 1'b1;
        if (mode) begin
          rr_ptr <= gnt;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_REG_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= 16'd0;
    end else if (xfer) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule
